// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } arb_state_t;

    // The header byte is tagged by its MSB so a receiver can tell it from payload.
    function automatic int hdr_mark_bit(input int data_length);
        return data_length - 1;
    endfunction

    localparam int DataLengthDefault = 8;
    localparam int HdrMarkBit        = hdr_mark_bit(DataLengthDefault);

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set bit of valid_i at or after ptr_i, wrapping.
module uart_rr_pick #(
    parameter int NumReq = 4,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic              found_o,
    output logic [NumReq-1:0] grant_o,
    output logic [IdxW-1:0]   idx_o
);

    int cand;

    always_comb begin
        found_o = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        cand    = 0;
        for (int i = 0; i < NumReq; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!found_o && valid_i[cand[IdxW-1:0]]) begin
                found_o                  = 1'b1;
                grant_o[cand[IdxW-1:0]]  = 1'b1;
                idx_o                    = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet scheduler feeding one uart_tx through a one-entry FIFO-style slot.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NumReq     = 4,
    parameter int DataLength = 8,
    parameter int HeaderEn   = 1,
    parameter int MaxBurst   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NumReq-1:0]            i_req_valid,
    input  logic [NumReq*DataLength-1:0] i_req_data,
    input  logic [NumReq-1:0]            i_req_last,
    output logic [NumReq-1:0]            o_req_ready,
    output logic [NumReq-1:0]            o_grant,
    output logic                         o_busy,
    output logic [DataLength-1:0]        o_tx_fifo_data,
    output logic                         o_tx_fifo_empty,
    input  logic                         i_tx_fifo_read_en
);

    localparam int IdxW   = $clog2(NumReq);
    localparam int CntW   = $clog2(MaxBurst + 1);
    localparam int HdrBit = hdr_mark_bit(DataLength);

    arb_state_t            state_q, state_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]       gidx_q, gidx_d;
    logic [NumReq-1:0]     grant_q, grant_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DataLength-1:0] out_data_q, out_data_d;

    logic [DataLength-1:0] req_bytes [NumReq];

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
            assign req_bytes[gi] = i_req_data[gi*DataLength +: DataLength];
        end
    endgenerate

    logic              pick_found;
    logic [NumReq-1:0] pick_grant;
    logic [IdxW-1:0]   pick_idx;

    uart_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .valid_i (i_req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    logic                  slot_free;
    logic [NumReq-1:0]     req_ready;
    logic                  accept;
    logic                  burst_done;
    logic [DataLength-1:0] hdr_byte;
    logic [IdxW-1:0]       next_ptr;

    // Ready is built only from registered state and the pop, never from request inputs.
    assign slot_free  = !out_valid_q || i_tx_fifo_read_en;
    assign req_ready  = (state_q == ST_PAYLOAD && slot_free) ? grant_q : '0;
    assign accept     = i_req_valid[gidx_q] && req_ready[gidx_q];
    assign burst_done = (cnt_q == CntW'(MaxBurst - 1));
    assign next_ptr   = (gidx_q == IdxW'(NumReq - 1)) ? '0 : gidx_q + IdxW'(1);

    always_comb begin
        hdr_byte               = '0;
        hdr_byte[HdrBit]       = 1'b1;
        hdr_byte[IdxW-1:0]     = gidx_q;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !i_tx_fifo_read_en;
        out_data_d  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_grant;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = (HeaderEn != 0) ? ST_HEADER : ST_PAYLOAD;
                end
            end
            ST_HEADER: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = hdr_byte;
                    state_d     = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = req_bytes[gidx_q];
                    cnt_d       = cnt_q + CntW'(1);
                    if (i_req_last[gidx_q] || burst_done) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign o_req_ready     = req_ready;
    assign o_grant         = grant_q;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_tx_fifo_data  = out_data_q;
    assign o_tx_fifo_empty = !out_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table plus packet-level sequences.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DL = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DL-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   ready;
    logic [NR-1:0]   grant;
    logic            busy;
    logic [DL-1:0]   fdata;
    logic            fempty;
    logic            read_en = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [8:0] srcq [NR][$];
    logic [7:0] got [$];
    logic [7:0] expq [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NumReq     (NR),
        .DataLength (DL),
        .HeaderEn   (1),
        .MaxBurst   (4)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req_valid       (req_valid),
        .i_req_data        (req_data),
        .i_req_last        (req_last),
        .o_req_ready       (ready),
        .o_grant           (grant),
        .o_busy            (busy),
        .o_tx_fifo_data    (fdata),
        .o_tx_fifo_empty   (fempty),
        .i_tx_fifo_read_en (read_en)
    );

    typedef struct {
        logic [3:0] valid;
        logic       rd;
        logic [3:0] exp_ready;
        logic [3:0] exp_grant;
        logic       exp_busy;
        logic       exp_empty;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive the requester queues and pop at negedge, sample 1 ns later.
    task automatic step(input logic rd, input logic rs);
        logic [8:0] head;
        @(negedge clk);
        rst     = rs;
        read_en = rd;
        for (int k = 0; k < NR; k++) begin
            if (srcq[k].size() > 0) begin
                head                = srcq[k][0];
                req_valid[k]        = 1'b1;
                req_data[k*DL +: DL] = head[7:0];
                req_last[k]         = head[8];
            end else begin
                req_valid[k] = 1'b0;
                req_last[k]  = 1'b0;
            end
        end
        #1;
        chk("ready_onehot", 32'($countones(ready) <= 1), 32'd1);
        for (int k = 0; k < NR; k++) begin
            if (!rs && req_valid[k] && ready[k]) void'(srcq[k].pop_front());
        end
        if (!rs && rd && !fempty) got.push_back(fdata);
    endtask

    task automatic run_until(input string name, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (got.size() < n && cyc < budget) begin
            step(1'b1, 1'b0);
            cyc++;
        end
        chk({name, "_timeout"}, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic cmp_bytes(input string name);
        chk({name, "_count"}, 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(expq[i]));
        end
        $display("%s: %0d bytes popped", name, got.size());
        got.delete();
        expq.delete();
    endtask

    task automatic clear_src();
        for (int k = 0; k < NR; k++) srcq[k].delete();
    endtask

    initial begin
        // valid, rd, exp_ready, exp_grant, busy, empty, data (data checked only when held)
        vecs[0]  = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h00};
        vecs[1]  = '{4'b0010, 1'b1, 4'b0000, 4'b0010, 1'b1, 1'b1, 8'h00};
        vecs[2]  = '{4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'h81};
        vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA5};
        vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h00};
        vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h00};
        vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h00};
        vecs[7]  = '{4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h00};
        vecs[8]  = '{4'b1001, 1'b1, 4'b0000, 4'b1000, 1'b1, 1'b1, 8'h00};
        vecs[9]  = '{4'b1001, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0, 8'h83};
        vecs[10] = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h33};
        vecs[11] = '{4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b1, 8'h00};
        vecs[12] = '{4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'h80};
        vecs[13] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h11};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h00};

        // Reset values
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_empty", 32'(fempty), 32'h1);
        chk("rst_data", 32'(fdata), 32'h0);
        $display("reset: ready=%0h grant=%0h busy=%0b empty=%0b data=%0h", ready, grant, busy, fempty, fdata);

        // Cycle table: single 0xA5 from r1, rr_ptr effect, idle pops
        req_data = {8'h33, 8'h22, 8'hA5, 8'h11};
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst       = 1'b0;
            req_valid = vecs[i].valid;
            req_last  = 4'hF;
            read_en   = vecs[i].rd;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].exp_ready));
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("v%0d_empty", i), 32'(fempty), 32'(vecs[i].exp_empty));
            if (!vecs[i].exp_empty) chk($sformatf("v%0d_data", i), 32'(fdata), 32'(vecs[i].exp_data));
            $display("vec %0d: valid=%b rd=%b ready=%b grant=%b busy=%b empty=%b data=%0h",
                     i, vecs[i].valid, vecs[i].rd, ready, grant, busy, fempty, fdata);
        end

        // Requesters 0 and 2 contend from reset; r0 must come back first afterwards
        step(1'b0, 1'b1);
        clear_src();
        got.delete();
        srcq[0].push_back(9'h010); srcq[0].push_back(9'h111); srcq[0].push_back(9'h112);
        srcq[2].push_back(9'h020); srcq[2].push_back(9'h121); srcq[2].push_back(9'h122);
        run_until("rr_two", 10, 80);
        expq = '{8'h80, 8'h10, 8'h11, 8'h82, 8'h20, 8'h21, 8'h80, 8'h12, 8'h82, 8'h22};
        cmp_bytes("rr_two");

        // Burst limit of 4 splits a 6-byte packet into two grants
        for (int b = 0; b < 6; b++) srcq[3].push_back({(b == 5), 8'(8'h30 + b)});
        run_until("burst", 8, 80);
        expq = '{8'h83, 8'h30, 8'h31, 8'h32, 8'h33, 8'h83, 8'h34, 8'h35};
        cmp_bytes("burst");

        // Downstream stall: header held, no ready; then pop+load back to back
        srcq[1].push_back(9'h040); srcq[1].push_back(9'h141);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int c = 0; c < 50; c++) begin
            step(1'b0, 1'b0);
            chk("stall_ready", 32'(ready), 32'h0);
            chk("stall_empty", 32'(fempty), 32'h0);
            chk("stall_data", 32'(fdata), 32'h81);
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0);
            chk($sformatf("resume_empty%0d", c), 32'(fempty), 32'h0);
        end
        expq = '{8'h81, 8'h40, 8'h41};
        cmp_bytes("stall");

        // Reset while PAYLOAD holds a byte (rr_ptr is 2 beforehand)
        srcq[2].push_back(9'h050); srcq[2].push_back(9'h051); srcq[2].push_back(9'h152);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        chk("pre_rst_empty", 32'(fempty), 32'h0);
        clear_src();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("midrst_empty", 32'(fempty), 32'h1);
        chk("midrst_grant", 32'(grant), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ready", 32'(ready), 32'h0);
        $display("mid-packet reset: empty=%0b grant=%0h busy=%0b", fempty, grant, busy);
        got.delete();
        srcq[1].push_back(9'h161);
        srcq[3].push_back(9'h163);
        run_until("after_rst", 4, 40);
        expq = '{8'h81, 8'h61, 8'h83, 8'h63};
        cmp_bytes("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
